// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner and instruction fetch with single outstanding request and 2-entry output queue
module if_fetch_stage #(
  parameter int PC_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  output logic                   imem_req_o,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic                   valid_o,
  output logic [PC_WIDTH-1:0]    pc_plus4_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic                   if_flush_o
);
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d, out_pc_q, out_pc_d;
  logic out_q, out_d, kill_q, kill_d;
  logic [PC_WIDTH-1:0] pc4_q [2];
  logic [PC_WIDTH-1:0] pc4_d [2];
  logic [INSTR_WIDTH-1:0] ins_q [2];
  logic [INSTR_WIDTH-1:0] ins_d [2];
  logic rd_q, rd_d, wr_q, wr_d;
  logic [1:0] cnt_q, cnt_d;
  logic grant, resp, push, pop;
  always_comb begin
    imem_req_o = !rst_i && !out_q && cnt_q < 2'd2 && !redirect_i;
    imem_addr_o = fetch_pc_q;
    if_flush_o = redirect_i && !rst_i;
    valid_o = cnt_q != 2'd0;
    pc_plus4_o = valid_o ? pc4_q[rd_q] : '0;
    instr_o = valid_o ? ins_q[rd_q] : '0;
    grant = imem_req_o && imem_gnt_i;
    resp = imem_rvalid_i && out_q;
    push = resp && !kill_q && !redirect_i;
    pop = valid_o && !stall_i && !redirect_i;
    fetch_pc_d = fetch_pc_q;
    out_pc_d = out_pc_q;
    out_d = out_q;
    kill_d = kill_q;
    pc4_d = pc4_q;
    ins_d = ins_q;
    rd_d = rd_q;
    wr_d = wr_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~PC_WIDTH'(3);
      cnt_d = '0;
      rd_d = 1'b0;
      wr_d = 1'b0;
      // a response landing now retires the stale request; otherwise its later response must be dropped
      out_d = out_q && !imem_rvalid_i;
      kill_d = out_d;
    end else begin
      if (grant) begin
        out_d = 1'b1;
        out_pc_d = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
      end
      if (resp) begin
        out_d = 1'b0;
        kill_d = 1'b0;
      end
      if (push) begin
        pc4_d[wr_q] = out_pc_q + PC_WIDTH'(4);
        ins_d[wr_q] = imem_rdata_i;
        wr_d = !wr_q;
      end
      if (pop) rd_d = !rd_q;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      out_q <= 1'b0;
      kill_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q <= out_d;
      kill_q <= kill_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    out_pc_q <= out_pc_d;
    pc4_q <= pc4_d;
    ins_q <= ins_d;
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed cycle-by-cycle checks of fetch, stall, redirect, wrap and reset
module tb_if_fetch_stage;
  logic clk = 1'b0, rst, stall, redirect, gnt;
  logic [31:0] rpc, addr, rdata, pc4, instr;
  logic req, rvalid, valid, flush;
  logic pend;
  logic [31:0] paddr;
  int lat, wt, n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  if_fetch_stage dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(rpc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt), .imem_rvalid_i(rvalid),
    .imem_rdata_i(rdata), .valid_o(valid), .pc_plus4_o(pc4), .instr_o(instr), .if_flush_o(flush)
  );
  // memory model: response lat cycles after grant, data tagged with its address
  assign rvalid = pend && wt == 0;
  assign rdata = paddr | 32'hA000_0000;
  always @(posedge clk) begin
    if (rst) pend <= 1'b0;
    else if (req && gnt) begin
      pend <= 1'b1;
      paddr <= addr;
      wt <= lat - 1;
    end else if (pend && wt == 0) pend <= 1'b0;
    else if (pend) wt <= wt - 1;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1; stall = 0; redirect = 1; rpc = 0; gnt = 1; lat = 1; pend = 0; paddr = 0; wt = 0;
    cyc(); #1;
    chk("rst_req", req, 0); chk("rst_flush", flush, 0);
    chk("rst_valid", valid, 0); chk("rst_pc4", pc4, 0); chk("rst_instr", instr, 0);
    cyc(); rst = 0; redirect = 0; #1;
    chk("a_req", req, 1); chk("a_addr", addr, 0); chk("a_valid", valid, 0);
    cyc(); #1;
    chk("b_req", req, 0); chk("b_valid", valid, 0);
    cyc(); stall = 1; #1;
    chk("c_valid", valid, 1); chk("c_pc4", pc4, 4); chk("c_instr", instr, 32'hA000_0000);
    chk("c_req", req, 1); chk("c_addr", addr, 4);
    cyc(); #1;
    chk("d_req", req, 0); chk("d_pc4", pc4, 4);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("stall_req", req, 0); chk("stall_valid", valid, 1);
      chk("stall_pc4", pc4, 4); chk("stall_instr", instr, 32'hA000_0000);
    end
    cyc(); stall = 0; #1;
    chk("h_pc4", pc4, 4); chk("h_req", req, 0);
    cyc(); lat = 2; #1;
    chk("i_pc4", pc4, 8); chk("i_instr", instr, 32'hA000_0004);
    chk("i_req", req, 1); chk("i_addr", addr, 8);
    cyc(); redirect = 1; rpc = 32'h100; #1;
    chk("j_flush", flush, 1); chk("j_req", req, 0); chk("j_valid", valid, 0);
    cyc(); redirect = 0; #1;
    chk("k_valid", valid, 0); chk("k_flush", flush, 0); chk("k_req", req, 0);
    cyc(); #1;
    chk("l_req", req, 1); chk("l_addr", addr, 32'h100); chk("l_valid", valid, 0);
    cyc(); #1;
    chk("m_req", req, 0); chk("m_valid", valid, 0);
    cyc(); #1;
    chk("n_valid", valid, 0);
    cyc(); lat = 1; stall = 1; #1;
    chk("o_valid", valid, 1); chk("o_pc4", pc4, 32'h104); chk("o_instr", instr, 32'hA000_0100);
    chk("o_req", req, 1); chk("o_addr", addr, 32'h104);
    cyc(); redirect = 1; rpc = 32'h200; #1;
    chk("p_flush", flush, 1); chk("p_req", req, 0); chk("p_valid", valid, 1);
    cyc(); redirect = 0; #1;
    chk("q_valid", valid, 0); chk("q_req", req, 1); chk("q_addr", addr, 32'h200);
    cyc(); #1;
    chk("r_req", req, 0); chk("r_valid", valid, 0);
    cyc(); stall = 0; redirect = 1; rpc = 32'hFFFF_FFFE; #1;
    chk("s_flush", flush, 1); chk("s_req", req, 0);
    chk("s_pc4", pc4, 32'h204); chk("s_instr", instr, 32'hA000_0200);
    cyc(); redirect = 0; #1;
    chk("t_valid", valid, 0); chk("t_req", req, 1); chk("t_addr", addr, 32'hFFFF_FFFC);
    cyc(); #1;
    chk("u_req", req, 0); chk("u_valid", valid, 0);
    cyc(); stall = 1; lat = 2; #1;
    chk("v_valid", valid, 1); chk("v_pc4", pc4, 0); chk("v_instr", instr, 32'hFFFF_FFFC);
    chk("v_req", req, 1); chk("v_addr", addr, 0);
    cyc(); rst = 1; redirect = 1; #1;
    chk("w_req", req, 0); chk("w_flush", flush, 0);
    cyc(); redirect = 0; #1;
    chk("x_valid", valid, 0); chk("x_pc4", pc4, 0); chk("x_instr", instr, 0); chk("x_req", req, 0);
    cyc(); rst = 0; stall = 0; lat = 1; #1;
    chk("y_req", req, 1); chk("y_addr", addr, 0);
    cyc(); #1;
    chk("z_valid", valid, 0);
    cyc(); #1;
    chk("aa_valid", valid, 1); chk("aa_pc4", pc4, 4); chk("aa_instr", instr, 32'hA000_0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
